// File: rtl/viterbi_ctrl.sv
// Frame sequencer for the K=3 Viterbi datapath: symbol intake, ACS/tail strobes, traceback, LIFO reversal, output.
// Optional abort input is enabled by defining VITERBI_CTRL_ABORT_EN.
module viterbi_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int TAIL_LEN  = 2,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef VITERBI_CTRL_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic              sym_valid,
    input  logic [1:0]        sym_in,
    output logic              sym_ready,
    output logic [1:0]        dec_in,
    output logic              pm_init,
    output logic              acs_en,
    output logic              surv_wr_en,
    output logic [ADDR_W-1:0] surv_addr,
    output logic              tb_en,
    input  logic              tb_bit,
    output logic              out_valid,
    output logic              out_bit,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int TOTAL_LEN = FRAME_LEN + TAIL_LEN;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    localparam logic [ADDR_W-1:0] LAST_DATA  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] FIRST_TAIL = ADDR_W'(FRAME_LEN);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(TOTAL_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, INIT, ACS, TAIL, GAP, TB, OUT
    } state_t;

    state_t                state;
    logic [ADDR_W-1:0]     cnt;
    logic [ADDR_W-1:0]     cnt_next;
    logic [IDX_W-1:0]      idx;
    logic [FRAME_LEN-1:0]  lifo;

    assign cnt_next  = (cnt == LAST_ADDR) ? cnt : cnt + 1'b1;
    assign sym_ready = (state == ACS);
    assign out_valid = (state == OUT);
    assign out_bit   = lifo[idx];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dec_in     <= 2'b00;
            pm_init    <= 1'b0;
            acs_en     <= 1'b0;
            surv_wr_en <= 1'b0;
            surv_addr  <= '0;
            tb_en      <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            lifo       <= '0;
        end
`ifdef VITERBI_CTRL_ABORT_EN
        else if (abort && state != IDLE) begin
            // Abandon the frame silently; stale traceback bits must not leak into a later frame.
            state      <= IDLE;
            pm_init    <= 1'b0;
            acs_en     <= 1'b0;
            surv_wr_en <= 1'b0;
            tb_en      <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            lifo       <= '0;
        end
`endif
        else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= INIT;
                        pm_init <= 1'b1;
                        cnt     <= '0;
                        idx     <= '0;
                    end
                end
                INIT: begin
                    pm_init <= 1'b0;
                    state   <= ACS;
                end
                ACS: begin
                    if (sym_valid) begin
                        dec_in     <= sym_in;
                        acs_en     <= 1'b1;
                        surv_wr_en <= 1'b1;
                        surv_addr  <= cnt;
                        cnt        <= cnt_next;
                        if (cnt == LAST_DATA) state <= TAIL;
                    end else begin
                        acs_en     <= 1'b0;
                        surv_wr_en <= 1'b0;
                    end
                end
                TAIL: begin
                    // Zero flush symbols drive the trellis back to state 0 for traceback.
                    dec_in     <= 2'b00;
                    acs_en     <= 1'b1;
                    surv_wr_en <= 1'b1;
                    surv_addr  <= cnt;
                    cnt        <= cnt_next;
                    if (cnt == LAST_ADDR) state <= GAP;
                end
                GAP: begin
                    acs_en     <= 1'b0;
                    surv_wr_en <= 1'b0;
                    state      <= TB;
                end
                TB: begin
                    // First cycle only arms tb_en; each later edge captures the bit for the address shown.
                    if (!tb_en) begin
                        tb_en     <= 1'b1;
                        surv_addr <= LAST_ADDR;
                    end else begin
                        if (surv_addr < FIRST_TAIL) lifo[surv_addr[IDX_W-1:0]] <= tb_bit;
                        if (surv_addr == '0) begin
                            tb_en <= 1'b0;
                            idx   <= '0;
                            state <= OUT;
                        end else begin
                            surv_addr <= surv_addr - 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Directed self-checking bench for viterbi_ctrl (FRAME_LEN=16, TAIL_LEN=2, ADDR_W=5).
module tb_viterbi_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sym_valid;
    logic [1:0] sym_in;
    logic       sym_ready;
    logic [1:0] dec_in;
    logic       pm_init;
    logic       acs_en;
    logic       surv_wr_en;
    logic [4:0] surv_addr;
    logic       tb_en;
    logic       tb_bit;
    logic       out_valid;
    logic       out_bit;
    logic       out_ready;
    logic       busy;
    logic       done;
`ifdef VITERBI_CTRL_ABORT_EN
    logic       abort = 1'b0;
`endif

    int   checks = 0;
    int   errors = 0;
    logic tb_mode = 1'b0;
    logic [1:0] pat [4] = '{2'b11, 2'b10, 2'b01, 2'b00};

    // Survivor memory stand-in: decoded bit is a fixed function of the read address.
    assign tb_bit = tb_mode ? surv_addr[1] : surv_addr[0];

    always #5 clk = ~clk;

    viterbi_ctrl #(.FRAME_LEN(16), .TAIL_LEN(2), .ADDR_W(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef VITERBI_CTRL_ABORT_EN
        .abort(abort),
`endif
        .start(start),
        .sym_valid(sym_valid),
        .sym_in(sym_in),
        .sym_ready(sym_ready),
        .dec_in(dec_in),
        .pm_init(pm_init),
        .acs_en(acs_en),
        .surv_wr_en(surv_wr_en),
        .surv_addr(surv_addr),
        .tb_en(tb_en),
        .tb_bit(tb_bit),
        .out_valid(out_valid),
        .out_bit(out_bit),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sym_valid = 1'b0; sym_in = 2'b00; out_ready = 1'b1;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (sym_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || tb_en !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got ready=%b ov=%b done=%b tb=%b expected all 0", sym_ready, out_valid, done, tb_en); end
        rst_n = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0; sym_valid = 1'b1; sym_in = 2'b11;
        cyc();
        repeat (5) cyc();
        checks++; if (acs_en !== 1'b1 || surv_addr !== 5'd4) begin
            errors++; $display("FAIL reset_pre_acs: got acs=%b addr=%0d expected 1/4", acs_en, surv_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || acs_en !== 1'b0) begin
            errors++; $display("FAIL reset_async: got busy=%b acs=%b expected 0/0", busy, acs_en); end
        checks++; if (dec_in !== 2'b00 || surv_addr !== 5'd0) begin
            errors++; $display("FAIL reset_data: got dec=%b addr=%0d expected 00/0", dec_in, surv_addr); end
        sym_valid = 1'b0;
        #3 rst_n = 1'b1;
        repeat (4) cyc();
        checks++; if (busy !== 1'b0 || pm_init !== 1'b0 || sym_ready !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got busy=%b pm=%b ready=%b expected 0", busy, pm_init, sym_ready); end
    endtask

    // Runs one full frame from IDLE, checking every phase against a cycle model.
    task automatic run_frame(input string name, input int vmode, input int bp_idx,
                             input logic tb_sel, input logic start_in_tb);
        int acc, wr_addr, tail_left, pm_cnt, tb_cnt, out_n, stall, done_cnt;
        int post, vk, last_acs, run, max_run, xfer16;
        logic accept_now, xfer_now, exp_acs, exp_ready, exp_ov, exp_bit;
        logic [1:0] exp_dec;
        acc = 0; wr_addr = 0; tail_left = 0; pm_cnt = 0; tb_cnt = 0; out_n = 0; stall = 0;
        done_cnt = 0; post = 0; vk = 0; last_acs = -10; run = 0; max_run = 0; xfer16 = -1;
        tb_mode = tb_sel; out_ready = 1'b1; sym_in = pat[0]; sym_valid = 1'b1; start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            accept_now = sym_ready && sym_valid;
            xfer_now   = out_valid && out_ready;
            cyc();
            start = 1'b0;
            exp_acs = 1'b0;
            if (accept_now) begin
                acc++; exp_acs = 1'b1;
                if (acc == 16) tail_left = 2;
            end else if (tail_left > 0) begin
                exp_acs = 1'b1; tail_left--;
            end
            checks++; if (acs_en !== exp_acs || surv_wr_en !== exp_acs) begin
                errors++; $display("FAIL %s acs_en cyc %0d: got %b/%b expected %b", name, c, acs_en, surv_wr_en, exp_acs); end
            if (exp_acs) begin
                exp_dec = (wr_addr < 16) ? pat[wr_addr % 4] : 2'b00;
                checks++; if (surv_addr !== 5'(wr_addr) || dec_in !== exp_dec) begin
                    errors++; $display("FAIL %s write %0d: got addr=%0d dec=%b expected addr=%0d dec=%b",
                                       name, wr_addr, surv_addr, dec_in, wr_addr, exp_dec); end
                wr_addr++; last_acs = c; run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (pm_init) pm_cnt++;
            exp_ready = (pm_cnt >= 1) && !pm_init && (acc < 16);
            checks++; if (sym_ready !== exp_ready) begin
                errors++; $display("FAIL %s sym_ready cyc %0d: got %b expected %b", name, c, sym_ready, exp_ready); end
            if (tb_en) begin
                if (tb_cnt == 0) begin
                    checks++; if (c - last_acs != 2) begin
                        errors++; $display("FAIL %s tb_gap: got %0d idle cycles expected 1", name, c - last_acs - 1); end
                end
                checks++; if (surv_addr !== 5'(17 - tb_cnt)) begin
                    errors++; $display("FAIL %s tb_addr step %0d: got %0d expected %0d", name, tb_cnt, surv_addr, 17 - tb_cnt); end
                tb_cnt++;
                if (start_in_tb && tb_cnt == 5) start = 1'b1;
            end
            if (xfer_now) begin
                out_n++;
                if (out_n == 16) xfer16 = c;
            end
            exp_ov = (tb_cnt == 18) && !tb_en && (out_n < 16);
            checks++; if (out_valid !== exp_ov) begin
                errors++; $display("FAIL %s out_valid cyc %0d: got %b expected %b", name, c, out_valid, exp_ov); end
            if (exp_ov) begin
                exp_bit = 1'((out_n >> tb_sel) & 1);
                checks++; if (out_bit !== exp_bit) begin
                    errors++; $display("FAIL %s out_bit idx %0d: got %b expected %b", name, out_n, out_bit, exp_bit); end
            end
            if (done) begin
                done_cnt++;
                checks++; if (xfer16 != c || busy !== 1'b0) begin
                    errors++; $display("FAIL %s done_timing: got last_xfer_cyc=%0d busy=%b expected %0d/0", name, xfer16, busy, c); end
            end
            if (out_valid && out_n == bp_idx && stall < 3) begin
                out_ready = 1'b0; stall++;
            end else begin
                out_ready = 1'b1;
            end
            sym_valid = (vmode == 0) || (vk % 3 == 0);
            if (sym_ready) vk++;
            sym_in = pat[acc % 4];
            if (done_cnt > 0) begin
                post++;
                if (post == 3) break;
            end
        end
        start = 1'b0; out_ready = 1'b1;
        checks++; if (done_cnt != 1) begin
            errors++; $display("FAIL %s done_count: got %0d expected 1", name, done_cnt); end
        checks++; if (pm_cnt != 1) begin
            errors++; $display("FAIL %s pm_init_cycles: got %0d expected 1", name, pm_cnt); end
        checks++; if (acc != 16 || wr_addr != 18) begin
            errors++; $display("FAIL %s accept_count: got acc=%0d writes=%0d expected 16/18", name, acc, wr_addr); end
        checks++; if (tb_cnt != 18 || out_n != 16) begin
            errors++; $display("FAIL %s tb_out_count: got tb=%0d out=%0d expected 18/16", name, tb_cnt, out_n); end
        if (vmode == 0) begin
            checks++; if (max_run != 18) begin
                errors++; $display("FAIL %s acs_contiguous: got %0d expected 18", name, max_run); end
        end
        if (bp_idx >= 0) begin
            checks++; if (stall != 3) begin
                errors++; $display("FAIL %s stall_cycles: got %0d expected 3", name, stall); end
        end
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL %s end_busy: got %b expected 0", name, busy); end
    endtask

    task automatic test_back_to_back();
        run_frame("back_to_back", 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_bubbles();
        run_frame("bubbles", 1, -1, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame("backpressure", 0, 4, 1'b0, 1'b0);
    endtask

    task automatic test_start_in_tb();
        run_frame("start_in_tb", 0, -1, 1'b1, 1'b1);
    endtask

`ifdef VITERBI_CTRL_ABORT_EN
    task automatic test_abort();
        int n;
        int done_seen;
        done_seen = 0;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got busy=%b expected 0", busy); end
        start = 1'b1; sym_valid = 1'b1; sym_in = 2'b01;
        for (n = 0; n < 100; n++) begin
            cyc();
            start = 1'b0;
            if (tb_en) break;
        end
        checks++; if (tb_en !== 1'b1) begin
            errors++; $display("FAIL abort_reach_tb: got tb_en=%b expected 1", tb_en); end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || tb_en !== 1'b0 || out_valid !== 1'b0 || sym_ready !== 1'b0) begin
            errors++; $display("FAIL abort_tb: got busy=%b tb=%b ov=%b ready=%b expected 0", busy, tb_en, out_valid, sym_ready); end
        repeat (20) begin
            cyc();
            if (done) done_seen++;
        end
        checks++; if (done_seen != 0) begin
            errors++; $display("FAIL abort_done: got %0d pulses expected 0", done_seen); end
        run_frame("after_abort", 0, -1, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_backpressure();
        test_start_in_tb();
`ifdef VITERBI_CTRL_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/viterbi_ctrl.md
Name: viterbi_ctrl

Overview:
Frame sequencer for the Viterbi decoder datapath (bmu → pmu → smu, K=3, 4 states). Accepts 2-bit received symbols over a valid/ready handshake and drives the symbol onto the bmu `dec_in` bus. Generates the pmu init/ACS strobes and the survivor-memory write addresses, then runs the smu traceback. Reverses the traceback bits in an internal LIFO and streams the decoded frame out in forward order.

Parameters:
FRAME_LEN, 16, data symbols (decoded bits) per frame, 2..(2^ADDR_W - TAIL_LEN)
TAIL_LEN, 2, zero flush symbols appended (K-1); traceback starts from state 0
ADDR_W, 5, survivor memory address width; must satisfy 2^ADDR_W >= FRAME_LEN+TAIL_LEN

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin frame; sampled only in IDLE
sym_valid  input  1  sym_in valid
sym_in  input  2  received code symbol
sym_ready  output  1  controller accepts symbol
dec_in  output  2  registered symbol to bmu
pm_init  output  1  pmu load: state0=0, others=max
acs_en  output  1  pmu ACS / smu survivor update this cycle
surv_wr_en  output  1  survivor memory write strobe (== acs_en)
surv_addr  output  ADDR_W  write address in ACS/TAIL, read address in TB
tb_en  output  1  smu traceback step
tb_bit  input  1  smu decoded bit for surv_addr, sampled at end of tb_en cycle
out_valid  output  1  out_bit valid
out_bit  output  1  decoded bit, forward order
out_ready  input  1  downstream accepts out_bit
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after last output bit

Behaviour:
- Reset (async, rst_n=0): state IDLE; dec_in=00, surv_addr=0, all 1-bit outputs 0, counters and LIFO cleared. Reset mid-frame aborts without done.
- L = FRAME_LEN+TAIL_LEN. All outputs are registered except sym_ready, out_valid, out_bit, busy.
- IDLE: start=1 → INIT. A start pulse in any other state is ignored.
- INIT (1 cycle): pm_init=1; → ACS.
- ACS: sym_ready=1. On each edge with sym_valid&sym_ready:
  - dec_in<=sym_in, acs_en<=1, surv_wr_en<=1, surv_addr<=cnt, cnt++.
  - No accept → acs_en/surv_wr_en<=0; dec_in holds.
  - After accept #FRAME_LEN → TAIL.
  - Latency: symbol visible on dec_in, with acs_en, exactly one cycle after acceptance.
- TAIL (TAIL_LEN cycles): sym_ready=0. Each edge registers dec_in=00, acs_en=1, surv_addr=FRAME_LEN+t; acs_en is contiguous with the last data symbol. Then GAP.
- GAP (1 cycle): acs_en=0. Lets the last survivor write settle. → TB.
- TB (L cycles): tb_en=1, surv_addr=L-1 down to 0.
  - tb_bit for addr < FRAME_LEN is stored to LIFO[addr].
  - The first TAIL_LEN bits are discarded.
  - → OUT.
- OUT: out_valid=1, out_bit=LIFO[idx], idx=0..FRAME_LEN-1; idx advances only on out_valid&out_ready.
  - Data holds stable while out_ready=0.
  - After the last transfer → IDLE, with done=1 on the following cycle.
- Width rules:
  - cnt and idx saturate at their terminal values; no wrap within a frame.
  - surv_addr never exceeds L-1.

Optional Feature:
VITERBI_CTRL_ABORT_EN: when defined, adds input `abort`. abort=1 in any non-IDLE state → IDLE on the next edge, with:
- acs_en, tb_en, out_valid, sym_ready and pm_init deasserted.
- LIFO contents invalidated.
- No done pulse.
- abort in IDLE has no effect.
When undefined, the port does not exist and frames always run to completion.

Test Plan:
1. Reset: rst_n=0 mid-ACS after 5 accepts → immediately busy=0, acs_en=0, dec_in=00, surv_addr=0. rst_n=1 with start=0 → stays IDLE.
2. Back-to-back frame: start, then 16 symbols (11,10,01,00 repeating) with sym_valid=1 →
   - pm_init high exactly 1 cycle.
   - 16 accepts; acs_en high 18 contiguous cycles.
   - surv_addr 0..17; dec_in echoes symbols, then 00,00.
   - sym_ready=0 after accept 16.
3. Bubbles: sym_valid pattern 1,0,0,1,... → acs_en only on the cycle after each accept; surv_addr has no gaps; ACS→TAIL only after the 16th accept.
4. Traceback/reversal: drive tb_bit = surv_addr[0] during TB →
   - tb_en 18 cycles, one GAP cycle before the first.
   - surv_addr 17→0.
   - out_bit sequence 0,1,0,1,... (16 bits); done pulses once.
5. Backpressure: out_ready=0 for 3 cycles at idx 4 → out_valid stays 1, out_bit=LIFO[4] held; resumes at idx 5 after out_ready=1.
6. start asserted during TB → ignored, frame completes normally. With VITERBI_CTRL_ABORT_EN: abort in TB → IDLE next cycle, no done pulse.
